// File: rtl/hist_pkg.sv
// Shared types and constants for the 256-bin byte histogram unit.
package hist_pkg;

    localparam int LANES  = 16;
    localparam int BYTE_W = 8;
    localparam int NBINS  = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/histogram_unit_if.sv
// Control, memory-read and readback bundle of the histogram unit.
interface histogram_unit_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 128
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic [7:0]        bin_idx;
    logic [CNT_W-1:0]  bin_cnt;

    modport slave (
        input  start, base_addr, num_words, mem_rdata, bin_idx,
        output mem_addr, mem_re, busy, done, bin_cnt
    );

    modport master (
        output start, base_addr, num_words, mem_rdata, bin_idx,
        input  mem_addr, mem_re, busy, done, bin_cnt
    );

endinterface

// File: rtl/hist_bin_bank.sv
// 256 saturating bin counters with a single increment port and a
// registered random-access read port.
module hist_bin_bank #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [7:0]       inc_idx,
    input  logic [7:0]       rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);

    import hist_pkg::*;

    logic [CNT_W-1:0] bin_q [NBINS];
    logic [CNT_W-1:0] bin_d [NBINS];
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;

    always_comb begin
        for (int i = 0; i < NBINS; i++) begin
            bin_d[i] = bin_q[i];
            if (clr) begin
                bin_d[i] = '0;
            end else if (inc_en && inc_idx == 8'(i) && bin_q[i] != '1) begin
                bin_d[i] = bin_q[i] + CNT_W'(1);
            end
        end
        rd_cnt_d = bin_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBINS; i++) begin
                bin_q[i] <= '0;
            end
            rd_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NBINS; i++) begin
                bin_q[i] <= bin_d[i];
            end
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;

endmodule

// File: rtl/histogram_unit.sv
// Byte histogram over N memory words: fetch, wait one cycle for read data,
// then scan the 16 byte lanes of the word one per cycle.
module histogram_unit #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 128
) (
    input logic              wrclk,
    input logic              rst_n,
    histogram_unit_if.slave  bus
);

    import hist_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] word_nxt;
    logic [3:0]        lane_q, lane_d;
    logic [DATA_W-1:0] word_q, word_d;

    logic              clr;
    logic              inc_en;
    logic [7:0]        inc_idx;

    assign word_nxt = word_cnt_q + ADDR_W'(1);
    assign inc_idx  = word_q[{lane_q, 3'b000} +: BYTE_W];

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        word_cnt_d = word_cnt_q;
        lane_d     = lane_q;
        word_d     = word_q;
        clr        = 1'b0;
        inc_en     = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_addr = '0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    num_d   = bus.num_words;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr        = 1'b1;
                word_cnt_d = '0;
                lane_d     = '0;
                state_d    = (num_q == '0) ? DONE : FETCH;
            end
            FETCH: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = base_q + word_cnt_q;
                state_d      = WAIT;
            end
            WAIT: begin
                word_d  = bus.mem_rdata;
                state_d = SCAN;
            end
            SCAN: begin
                inc_en = 1'b1;
                lane_d = lane_q + 4'd1;
                if (lane_q == 4'(LANES - 1)) begin
                    word_cnt_d = word_nxt;
                    state_d    = (word_nxt == num_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            word_cnt_q <= word_cnt_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
        end
    end

    hist_bin_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk     (wrclk),
        .rst_n   (rst_n),
        .clr     (clr),
        .inc_en  (inc_en),
        .inc_idx (inc_idx),
        .rd_idx  (bus.bin_idx),
        .rd_cnt  (bus.bin_cnt)
    );

endmodule

// File: tb/tb_histogram_unit.sv
// Directed bench for histogram_unit with a 1-cycle-latency memory model.
module tb_histogram_unit;

    logic wrclk = 1'b0;
    logic rst_n;

    always #5 wrclk = ~wrclk;

    histogram_unit_if #(.ADDR_W(8), .CNT_W(16), .DATA_W(128)) bus ();
    histogram_unit_if #(.ADDR_W(8), .CNT_W(4),  .DATA_W(128)) bus4 ();

    histogram_unit #(.ADDR_W(8), .CNT_W(16), .DATA_W(128)) dut (
        .wrclk (wrclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    histogram_unit #(.ADDR_W(8), .CNT_W(4), .DATA_W(128)) dut4 (
        .wrclk (wrclk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    logic [127:0] mem  [256];
    logic [127:0] mem4 [256];

    always @(posedge wrclk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus4.mem_re) bus4.mem_rdata <= mem4[bus4.mem_addr];
    end

    typedef struct {
        int         test;
        logic [7:0] idx;
        int         exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;
    int   model [256];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_bin(input logic [7:0] idx, output int cnt);
        @(negedge wrclk);
        bus.bin_idx = idx;
        @(negedge wrclk);
        cnt = int'(bus.bin_cnt);
    endtask

    task automatic build_model(input logic [7:0] base, input int n);
        logic [127:0] w;
        logic [7:0]   a;
        logic [7:0]   b;
        for (int i = 0; i < 256; i++) model[i] = 0;
        for (int k = 0; k < n; k++) begin
            a = base + 8'(k);
            w = mem[a];
            for (int l = 0; l < 16; l++) begin
                b = w[8*l +: 8];
                if (model[b] < 65535) model[b]++;
            end
        end
    endtask

    task automatic check_all(input string name, input int exp_sum);
        int bad = 0;
        int sum = 0;
        int c;
        for (int i = 0; i < 256; i++) begin
            read_bin(8'(i), c);
            sum += c;
            if (c != model[i]) bad++;
        end
        check({name, "_bad_bins"}, bad, 0);
        check({name, "_sum"}, sum, exp_sum);
    endtask

    task automatic check_vecs(input int test);
        int c;
        foreach (vecs[i]) begin
            if (vecs[i].test == test) begin
                read_bin(vecs[i].idx, c);
                check($sformatf("t%0d_bin_%02h", test, vecs[i].idx), c, vecs[i].exp);
            end
        end
    endtask

    task automatic run(input logic [7:0] base, input logic [7:0] n,
                       input int inject, output int done_cyc,
                       output int nre, output logic [7:0] addrs [4]);
        @(negedge wrclk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_words = n;
        @(negedge wrclk);
        bus.start = 1'b0;
        done_cyc  = -1;
        nre       = 0;
        for (int i = 0; i < 4; i++) addrs[i] = 8'h00;
        for (int c = 1; c <= 2000; c++) begin
            if (c > 1) @(negedge wrclk);
            if (c == 1) check("busy_in_clear", bus.busy, 1);
            if (c == inject) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h00;
                bus.num_words = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.mem_re) begin
                if (nre < 4) addrs[nre] = bus.mem_addr;
                nre++;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
        bus.start = 1'b0;
        @(negedge wrclk);
        check("done_one_cycle", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
    endtask

    initial begin
        int         dc;
        int         nre;
        logic [7:0] addrs [4];
        int         c;

        vecs.push_back('{1, 8'h00, 8});
        vecs.push_back('{1, 8'hff, 8});
        vecs.push_back('{1, 8'h01, 0});
        vecs.push_back('{2, 8'hff, 0});
        vecs.push_back('{2, 8'h00, 0});
        vecs.push_back('{3, 8'h7e, 15});
        vecs.push_back('{3, 8'h7d, 9});
        vecs.push_back('{3, 8'h7b, 9});
        vecs.push_back('{3, 8'h7a, 12});
        vecs.push_back('{3, 8'h81, 3});
        vecs.push_back('{5, 8'h00, 8});
        vecs.push_back('{5, 8'h7e, 0});
        vecs.push_back('{6, 8'h01, 16});
        vecs.push_back('{6, 8'h02, 16});
        vecs.push_back('{6, 8'h00, 0});

        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mem4[i] = '0;
        end
        mem[8'h10] = 128'hffffffffffffffff0000000000000000;
        for (int i = 0; i < 3; i++)
            mem[8'h20 + i] = 128'h7e7e7e7e7d7d7d7b7b7b7a7a7a7a7e81;
        mem[8'hff] = {16{8'h01}};
        mem[8'h00] = {16{8'h02}};
        mem4[8'h40] = {16{8'h55}};
        mem4[8'h41] = {16{8'h55}};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_words  = '0;
        bus.bin_idx    = '0;
        bus4.start     = 1'b0;
        bus4.base_addr = '0;
        bus4.num_words = '0;
        bus4.bin_idx   = '0;
        repeat (3) @(negedge wrclk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_bin_cnt", bus.bin_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge wrclk);

        // Test 1: single word, half 00 half ff
        run(8'h10, 8'd1, 0, dc, nre, addrs);
        check("t1_done_cycle", dc, 20);
        check("t1_reads", nre, 1);
        check("t1_addr0", addrs[0], 8'h10);
        build_model(8'h10, 1);
        check_all("t1", 16);
        check_vecs(1);

        // Test 2: empty run
        run(8'h30, 8'd0, 0, dc, nre, addrs);
        check("t2_done_cycle", dc, 2);
        check("t2_reads", nre, 0);
        build_model(8'h30, 0);
        check_all("t2", 0);
        check_vecs(2);

        // Test 3: three pixel words
        run(8'h20, 8'd3, 0, dc, nre, addrs);
        check("t3_done_cycle", dc, 56);
        check("t3_reads", nre, 3);
        check("t3_addr0", addrs[0], 8'h20);
        check("t3_addr2", addrs[2], 8'h22);
        build_model(8'h20, 3);
        check_all("t3", 48);
        check_vecs(3);

        // Test 4: 4-bit counters saturate at 15
        @(negedge wrclk);
        bus4.start     = 1'b1;
        bus4.base_addr = 8'h40;
        bus4.num_words = 8'd2;
        @(negedge wrclk);
        bus4.start = 1'b0;
        dc = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge wrclk);
            if (bus4.done) begin
                dc = k;
                break;
            end
        end
        check("t4_done_cycle", dc, 38);
        @(negedge wrclk);
        bus4.bin_idx = 8'h55;
        @(negedge wrclk);
        check("t4_bin55_sat", bus4.bin_cnt, 15);
        bus4.bin_idx = 8'h54;
        @(negedge wrclk);
        check("t4_bin54", bus4.bin_cnt, 0);

        // Test 5: reset during the scan of word 1
        bus.bin_idx = 8'h7e;
        @(negedge wrclk);
        bus.start     = 1'b1;
        bus.base_addr = 8'h20;
        bus.num_words = 8'd3;
        @(negedge wrclk);
        bus.start = 1'b0;
        repeat (24) @(negedge wrclk);
        check("t5_busy_pre", bus.busy, 1);
        check("t5_bin7e_partial", bus.bin_cnt, 6);
        rst_n = 1'b0;
        #1;
        check("t5_busy_async", bus.busy, 0);
        check("t5_bin_cnt_async", bus.bin_cnt, 0);
        check("t5_mem_re_async", bus.mem_re, 0);
        @(negedge wrclk);
        rst_n = 1'b1;
        read_bin(8'h7e, c);
        check("t5_bin7e_cleared", c, 0);
        run(8'h10, 8'd1, 0, dc, nre, addrs);
        check("t5_done_cycle", dc, 20);
        build_model(8'h10, 1);
        check_all("t5", 16);
        check_vecs(5);

        // Test 6: start while busy ignored, address wraps
        run(8'hff, 8'd2, 5, dc, nre, addrs);
        check("t6_done_cycle", dc, 38);
        check("t6_reads", nre, 2);
        check("t6_addr0", addrs[0], 8'hff);
        check("t6_addr1", addrs[1], 8'h00);
        build_model(8'hff, 2);
        check_all("t6", 32);
        check_vecs(6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
